seq_bit_serializer: RTL

Parallel-to-serial front end that feeds the serial bit input `x` of the sequence-detector FSMs (seq_det_101_moore / Mealy variant).
- Accepts WIDTH-bit words over a valid/ready handshake.
- Emits each word one bit per clock on `x`, with a qualifying `x_valid` strobe.
- Optional idle gap between words.
- Supports gapless back-to-back streaming, so patterns that span a word boundary reach the detector intact.

---
 rtl/seq_bit_serializer.sv | 121 ++++++++++++
 1 files changed

// File: rtl/seq_bit_serializer.sv
// Parallel-to-serial front end for the serial sequence detectors.
// Accepts words over valid/ready and emits one registered bit per clock with a valid strobe.
module seq_bit_serializer #(
  parameter int unsigned WIDTH     = 8,
  parameter int unsigned MSB_FIRST = 1,
  parameter int unsigned GAP       = 0,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] data_in,
  input  logic             data_valid,
  output logic             data_ready,
  output logic             x,
  output logic             x_valid,
  output logic             busy,
  output logic [CNT_W-1:0] words_sent
);

  localparam int unsigned BitW = $clog2(WIDTH);
  localparam int unsigned GapW = 8;
  localparam logic [BitW-1:0] LastBit = BitW'(WIDTH - 1);
  localparam logic [GapW-1:0] LastGap = (GAP == 0) ? '0 : GapW'(GAP - 1);
  localparam logic            NoGap   = (GAP == 0);
  localparam logic            MsbFirst = (MSB_FIRST != 0);

  typedef enum logic [1:0] {StIdle, StShift, StGap} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [BitW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [GapW-1:0]  gap_cnt_q, gap_cnt_d;
  logic             x_q, x_d;
  logic             x_valid_q, x_valid_d;
  logic [CNT_W-1:0] words_q, words_d;
  logic             load;
  logic             last_bit;

  assign x          = x_q;
  assign x_valid    = x_valid_q;
  assign words_sent = words_q;
  assign busy       = (state_q != StIdle);
  assign last_bit   = (bit_cnt_q == LastBit);

  always_comb begin
    state_d    = state_q;
    shreg_d    = shreg_q;
    bit_cnt_d  = bit_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    x_d        = 1'b0;
    x_valid_d  = 1'b0;
    words_d    = words_q;
    data_ready = 1'b0;
    load       = 1'b0;

    unique case (state_q)
      StIdle: begin
        data_ready = 1'b1;
        load       = data_valid;
      end
      StShift: begin
        // Ready in the last-bit cycle only when streaming gapless, so words chain without a bubble.
        data_ready = last_bit && NoGap;
        if (!last_bit) begin
          bit_cnt_d = bit_cnt_q + BitW'(1);
          x_d       = MsbFirst ? shreg_q[WIDTH-1] : shreg_q[0];
          shreg_d   = MsbFirst ? (shreg_q << 1) : (shreg_q >> 1);
          x_valid_d = 1'b1;
        end else begin
          words_d = words_q + CNT_W'(1);
          if (!NoGap) begin
            state_d   = StGap;
            gap_cnt_d = '0;
          end else if (data_valid) begin
            load = 1'b1;
          end else begin
            state_d = StIdle;
          end
        end
      end
      StGap: begin
        if (gap_cnt_q == LastGap) begin
          state_d = StIdle;
        end else begin
          gap_cnt_d = gap_cnt_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // The first bit leaves straight from data_in; the register keeps the remaining bits.
    if (load) begin
      state_d   = StShift;
      bit_cnt_d = '0;
      x_d       = MsbFirst ? data_in[WIDTH-1] : data_in[0];
      shreg_d   = MsbFirst ? (data_in << 1) : (data_in >> 1);
      x_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      shreg_q   <= '0;
      bit_cnt_q <= '0;
      gap_cnt_q <= '0;
      x_q       <= 1'b0;
      x_valid_q <= 1'b0;
      words_q   <= '0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      bit_cnt_q <= bit_cnt_d;
      gap_cnt_q <= gap_cnt_d;
      x_q       <= x_d;
      x_valid_q <= x_valid_d;
      words_q   <= words_d;
    end
  end

endmodule
